aud_play_ctrl: RTL and testbench
================================

AUD_PLAY_CTRL -- requirements
Module: aud_play_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, sample-memory address width in 16-bit words.
REQ-002 SHALL have port i_clk  input  1  system clock; all logic SHALL run on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports i_start, i_pause, i_stop  input  1 each  single-cycle command pulses.
REQ-005 SHALL have ports i_fast  input  1  1=fast and 0=slow; i_speed  input  3  factor N=i_speed+1 (1..8).
REQ-006 SHALL have port i_interp  input  1  in slow mode, 1=linear interpolation and 0=sample hold.
REQ-007 SHALL have port i_end_addr  input  ADDR_W  address of the last valid sample.
REQ-008 SHALL have ports o_sram_addr  output  ADDR_W and i_sram_data  input  16 (signed), async memory read port.
REQ-009 SHALL have ports o_dac_data  output  16 and o_player_en  output  1, the sample offered to the I2S player.
REQ-010 SHALL have port i_player_ack  input  1  one-cycle pulse; the player consumed o_dac_data.
REQ-011 SHALL have ports o_busy  output  1 (state != IDLE) and o_done  output  1 (one-cycle end-of-data pulse).

Function
REQ-012 SHALL implement states IDLE, FETCH, LATCH, PLAY, STEP, PAUSE.
REQ-013 IDLE + i_start SHALL clear addr to 0, prev to 0 and k to 0, then go to FETCH; all other commands in IDLE SHALL be ignored.
REQ-014 FETCH SHALL drive o_sram_addr=addr for one cycle, then go to LATCH; N, i_fast and i_interp SHALL be latched on FETCH entry.
REQ-015 LATCH SHALL register i_sram_data into cur at its end, then go to PLAY; memory read latency SHALL therefore be 2 cycles.
REQ-016 PLAY SHALL hold o_player_en=1 and o_dac_data stable until i_player_ack, then go to STEP; o_player_en SHALL be 0 in every other state.
REQ-017 Fast mode, in STEP: addr += N; if the new addr > i_end_addr then go to IDLE and pulse o_done; otherwise go to FETCH.
REQ-018 Slow mode, in STEP: if k < N-1 then k += 1 and go to PLAY; otherwise set k=0, prev=cur, addr += 1 and apply the end check of REQ-017.
REQ-019 Slow mode with interp=0 SHALL output cur; with interp=1 it SHALL output (prev*(N-k)+cur*k)/N, signed, 20-bit intermediate, truncated toward zero.
REQ-020 Fast mode and N=1 SHALL output cur unmodified.
REQ-021 Address arithmetic SHALL be ADDR_W+1 bits wide, so addr+N past 2^ADDR_W-1 ends playback rather than wrapping.
REQ-022 i_pause in FETCH, LATCH, PLAY or STEP SHALL set a sticky flag; STEP with the flag set SHALL complete its update, then enter PAUSE and clear the flag.
REQ-023 A pending sample in PLAY SHALL never be withdrawn by a pause; an ack in the same cycle as i_pause SHALL be honoured normally.
REQ-024 PAUSE + i_start SHALL go to FETCH at the current addr with k preserved.
REQ-025 If the end check fires in the same STEP as a pause, IDLE with o_done SHALL win.
REQ-026 i_stop SHALL take priority over every command in any non-IDLE state: next state IDLE, o_player_en=0, pause flag cleared, no o_done pulse.
REQ-027 i_start in FETCH, LATCH, PLAY or STEP SHALL be ignored.
REQ-028 i_player_ack outside PLAY SHALL be ignored.

Reset
REQ-029 i_rst SHALL immediately force state=IDLE and set addr, k, prev, cur, o_sram_addr and o_dac_data to 0, and o_player_en, o_busy and o_done to 0.
REQ-030 Reset during PLAY SHALL drop o_player_en in the same cycle without waiting for a clock edge.
REQ-031 The first i_start after reset release SHALL behave exactly as REQ-013.

Verification
REQ-032 Normal playback: mem[0..3]=100,200,300,400, end=3, fast, N=1, ack 3 cycles after each en -> outputs 100,200,300,400, then o_done pulses once and o_busy=0.
REQ-033 Fast mode: same memory, N=2 -> outputs 100,300, then addr=4>3 -> o_done.
REQ-034 Slow interpolation: mem[0..1]=0,800, slow, N=4, interp=1 -> outputs 0,0,0,0,0,200,400,600,then 800 x4 only if end allows; with end=1 -> o_done after the 8th ack; with mem[0]=-800 -> k=1 gives -600.
REQ-035 Pause/resume: i_pause during PLAY of sample 1 -> sample 1 is still acked, state PAUSE, o_player_en=0; i_start -> resumes at sample 2 with no sample lost or duplicated.
REQ-036 Stop and reset: i_stop together with ack -> IDLE and no o_done; i_rst mid-PLAY -> o_player_en=0 asynchronously, and a later start replays from address 0.

Source files
------------

// File: rtl/aud_play_ctrl.sv
// Sample playback controller: fetches 16-bit samples from an async SRAM and
// hands them to an I2S player at a fast (skip) or slow (hold/interpolate) rate.
module aud_play_ctrl #(
    parameter int ADDR_W = 20
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_pause,
    input  logic                     i_stop,
    input  logic                     i_fast,
    input  logic [2:0]               i_speed,
    input  logic                     i_interp,
    input  logic [ADDR_W-1:0]        i_end_addr,
    output logic [ADDR_W-1:0]        o_sram_addr,
    input  logic signed [15:0]       i_sram_data,
    output logic signed [15:0]       o_dac_data,
    output logic                     o_player_en,
    input  logic                     i_player_ack,
    output logic                     o_busy,
    output logic                     o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_PLAY,
        S_STEP,
        S_PAUSE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ADDR_W:0]    r_addr;
    logic [ADDR_W:0]    w_inc;
    logic [ADDR_W:0]    w_addr_nxt;
    logic [2:0]         r_k;
    logic [3:0]         r_n;
    logic               r_fast;
    logic               r_interp;
    logic               r_pause;
    logic               r_done;
    logic signed [15:0] r_prev;
    logic signed [15:0] r_cur;

    logic               w_last;
    logic               w_adv;
    logic               w_end;
    logic               w_clear;
    logic               w_load_cfg;
    logic               w_latch;
    logic               w_step;
    logic               w_done;

    // Weighted blend of prev and cur; 20 bits hold 8 * 32767 without overflow.
    function automatic logic signed [15:0] f_interp(
        input logic signed [15:0] prev,
        input logic signed [15:0] cur,
        input logic [2:0]         k,
        input logic [3:0]         n
    );
        logic signed [19:0] w_wp;
        logic signed [19:0] w_wc;
        logic signed [19:0] w_div;
        logic signed [19:0] w_acc;
        w_wp  = $signed({16'd0, n - {1'b0, k}});
        w_wc  = $signed({17'd0, k});
        w_div = $signed({16'd0, n});
        w_acc = 20'(prev) * w_wp + 20'(cur) * w_wc;
        return 16'(w_acc / w_div);
    endfunction

    // The extra address bit makes running past the top of memory end playback.
    assign w_inc      = r_fast ? (ADDR_W+1)'(r_n) : (ADDR_W+1)'(1);
    assign w_addr_nxt = r_addr + w_inc;
    assign w_last     = ({1'b0, r_k} >= (r_n - 4'd1));
    assign w_adv      = r_fast || w_last;
    assign w_end      = w_adv && (w_addr_nxt > {1'b0, i_end_addr});

    assign o_sram_addr = r_addr[ADDR_W-1:0];
    assign o_dac_data  = (r_fast || !r_interp) ? r_cur : f_interp(r_prev, r_cur, r_k, r_n);
    assign o_player_en = (r_state == S_PLAY);
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_load_cfg  = 1'b0;
        w_latch     = 1'b0;
        w_step      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_clear     = 1'b1;
                    w_load_cfg  = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_LATCH;
            S_LATCH: begin
                w_latch     = 1'b1;
                w_state_nxt = S_PLAY;
            end
            S_PLAY: begin
                if (i_player_ack) begin
                    w_state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                w_step = 1'b1;
                if (w_end) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_pause || i_pause) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_adv) begin
                    w_load_cfg  = 1'b1;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_PAUSE: begin
                if (i_start) begin
                    w_load_cfg  = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Stop overrides everything outside IDLE and suppresses the done pulse.
        if (r_state != S_IDLE && i_stop) begin
            w_state_nxt = S_IDLE;
            w_load_cfg  = 1'b0;
            w_step      = 1'b0;
            w_done      = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr   <= '0;
            r_k      <= '0;
            r_n      <= 4'd1;
            r_fast   <= 1'b0;
            r_interp <= 1'b0;
            r_prev   <= '0;
            r_cur    <= '0;
            r_pause  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_done;
            if (w_clear) begin
                r_addr <= '0;
                r_k    <= '0;
                r_prev <= '0;
            end
            if (w_load_cfg) begin
                r_n      <= {1'b0, i_speed} + 4'd1;
                r_fast   <= i_fast;
                r_interp <= i_interp;
            end
            if (w_latch) begin
                r_cur <= i_sram_data;
            end
            if (w_step) begin
                if (w_adv) begin
                    r_k    <= '0;
                    r_addr <= w_addr_nxt;
                    if (!r_fast) begin
                        r_prev <= r_cur;
                    end
                end else begin
                    r_k <= r_k + 3'd1;
                end
            end
            if (o_busy && i_stop) begin
                r_pause <= 1'b0;
            end else if (r_state == S_STEP) begin
                r_pause <= 1'b0;
            end else if (i_pause && (r_state == S_FETCH || r_state == S_LATCH || r_state == S_PLAY)) begin
                r_pause <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aud_play_ctrl.sv
// Scoreboard bench: a list-level playback model fills the expected-sample queue,
// a negedge monitor pops one entry each time the DUT offers a new sample.
module tb_aud_play_ctrl;

    logic               clk;
    logic               i_rst;
    logic               i_start;
    logic               i_pause;
    logic               i_stop;
    logic               i_fast;
    logic [2:0]         i_speed;
    logic               i_interp;
    logic [3:0]         i_end_addr;
    logic [3:0]         o_sram_addr;
    logic signed [15:0] i_sram_data;
    logic signed [15:0] o_dac_data;
    logic               o_player_en;
    logic               i_player_ack;
    logic               o_busy;
    logic               o_done;

    logic signed [15:0] mem [16];
    int                 exp_q [$];
    int                 n_tests;
    int                 n_fail;
    int                 done_seen;
    logic               en_d;
    logic signed [15:0] held;

    aud_play_ctrl #(.ADDR_W(4)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_pause      (i_pause),
        .i_stop       (i_stop),
        .i_fast       (i_fast),
        .i_speed      (i_speed),
        .i_interp     (i_interp),
        .i_end_addr   (i_end_addr),
        .o_sram_addr  (o_sram_addr),
        .i_sram_data  (i_sram_data),
        .o_dac_data   (o_dac_data),
        .o_player_en  (o_player_en),
        .i_player_ack (i_player_ack),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    assign i_sram_data = mem[o_sram_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Reference: the full list of samples the player should receive.
    task automatic build_expected(input bit fast, input int n, input bit interp, input int endaddr);
        exp_q.delete();
        if (fast) begin
            for (int a = 0; a <= endaddr; a += n) exp_q.push_back(int'(mem[a]));
        end else begin
            for (int a = 0; a <= endaddr; a++) begin
                int p;
                int c;
                p = (a == 0) ? 0 : int'(mem[a-1]);
                c = int'(mem[a]);
                for (int k = 0; k < n; k++)
                    exp_q.push_back(interp ? (p * (n - k) + c * k) / n : c);
            end
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    endtask

    always @(negedge clk) begin
        if (o_player_en && !en_d) begin
            if (exp_q.size() == 0) begin
                check("sample_extra", int'(o_dac_data), 99999);
            end else begin
                held = o_dac_data;
                check("sample", int'(o_dac_data), exp_q.pop_front());
            end
        end else if (o_player_en) begin
            check("sample_hold", int'(o_dac_data), int'(held));
        end
        if (o_done) begin
            check("done_after_last", exp_q.size(), 0);
            done_seen++;
        end
        en_d = o_player_en;
    end

    // mode: 0 run to end, 1 stop with an ack, 2 async reset mid-PLAY.
    // pmode: 0 no pause, 1 random pauses, 2 one pause during sample 1.
    task automatic run_case(input bit fast, input int spd, input bit interp, input int endaddr,
                            input int pmode, input int mode, input int ackd);
        int total, cnt, acks, low, stop_at, resumes, cyc;
        bit pdone;
        build_expected(fast, spd + 1, interp, endaddr);
        total   = exp_q.size();
        stop_at = (mode != 0) ? $urandom_range(0, total - 1) : -1;
        done_seen = 0;
        @(negedge clk);
        i_fast = fast; i_speed = spd[2:0]; i_interp = interp; i_end_addr = endaddr[3:0];
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cnt = -1; acks = 0; low = 0; resumes = 0; pdone = 1'b0;
        for (cyc = 0; cyc < 6000; cyc++) begin
            if (!o_busy) break;
            i_player_ack = 1'b0; i_pause = 1'b0; i_start = 1'b0; i_stop = 1'b0;
            if (mode == 2 && o_player_en && acks == stop_at) begin
                #2 i_rst = 1'b1;
                #1;
                check("rst_en_async", o_player_en, 0);
                check("rst_busy", o_busy, 0);
                check("rst_dac", int'(o_dac_data), 0);
                check("rst_addr", o_sram_addr, 0);
                @(negedge clk);
                i_rst = 1'b0;
                break;
            end
            if (o_player_en) begin
                if (cnt < 0) cnt = (ackd >= 0) ? ackd : $urandom_range(0, 3);
                if (cnt == 0) begin
                    i_player_ack = 1'b1;
                    if (mode == 1 && acks == stop_at) i_stop = 1'b1;
                    acks++;
                    cnt = -1;
                end else begin
                    cnt--;
                end
            end else begin
                cnt = -1;
            end
            if (!o_player_en) low++; else low = 0;
            if (low > 6) begin
                i_start = 1'b1;
                low = 0;
                resumes++;
            end
            if (pmode == 1 && $urandom_range(0, 15) == 0) i_pause = 1'b1;
            if (pmode == 2 && !pdone && o_player_en && acks == 1) begin
                i_pause = 1'b1;
                pdone = 1'b1;
            end
            @(negedge clk);
        end
        if (cyc >= 6000) check("timeout", cyc, 0);
        i_player_ack = 1'b0; i_pause = 1'b0; i_start = 1'b0; i_stop = 1'b0;
        repeat (3) @(negedge clk);
        if (mode == 0) begin
            check("done_count", done_seen, 1);
            check("queue_left", exp_q.size(), 0);
            if (pmode == 2) check("resumed_once", resumes, 1);
        end else begin
            check("no_done_on_abort", done_seen, 0);
            exp_q.delete();
        end
        check("idle_busy", o_busy, 0);
        check("idle_en", o_player_en, 0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; done_seen = 0; en_d = 1'b0; held = '0;
        i_rst = 1'b1; i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
        i_fast = 1'b0; i_speed = 3'd0; i_interp = 1'b0; i_end_addr = 4'd0; i_player_ack = 1'b0;
        fill_rand();
        repeat (2) @(negedge clk);
        check("reset_busy", o_busy, 0);
        check("reset_en", o_player_en, 0);
        check("reset_done", o_done, 0);
        check("reset_dac", int'(o_dac_data), 0);
        check("reset_addr", o_sram_addr, 0);
        i_rst = 1'b0;
        @(negedge clk);

        mem[0] = 100; mem[1] = 200; mem[2] = 300; mem[3] = 400;
        run_case(1'b1, 0, 1'b0, 3, 0, 0, 3);
        run_case(1'b1, 1, 1'b0, 3, 0, 0, 3);
        mem[0] = 0; mem[1] = 800;
        run_case(1'b0, 3, 1'b1, 1, 0, 0, -1);
        mem[0] = -800; mem[1] = 0;
        run_case(1'b0, 3, 1'b1, 1, 0, 0, -1);
        mem[0] = 100; mem[1] = 200; mem[2] = 300; mem[3] = 400;
        run_case(1'b1, 0, 1'b0, 3, 2, 0, -1);
        run_case(1'b0, 2, 1'b1, 3, 2, 0, -1);
        run_case(1'b1, 0, 1'b0, 3, 0, 1, -1);
        run_case(1'b1, 0, 1'b0, 3, 0, 2, -1);
        run_case(1'b1, 0, 1'b0, 3, 0, 0, -1);
        fill_rand();
        run_case(1'b1, 2, 1'b0, 15, 0, 0, -1);
        run_case(1'b1, 7, 1'b0, 15, 1, 0, -1);
        run_case(1'b0, 0, 1'b0, 15, 0, 0, -1);
        for (int t = 0; t < 16; t++) begin
            fill_rand();
            run_case(1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 15), $urandom_range(0, 1),
                     ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
